// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M definitions: funct7 tag for M-ops and funct3 op encodings.
// The decoder and the EX-stage multiply/divide sequencer both import these.
package muldiv_sequencer_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // DIV and REM treat their operands as two's complement.
    function automatic logic is_signed_div(input logic [2:0] f3);
        return f3[2] && !f3[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_restoring_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per step.
// Outputs show the post-step values so the caller can retire on the final step.
module restoring_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] rem_q, quo_q, dsr_q;
    logic [W-1:0] shifted;
    logic         fits;

    // quo_q starts as the dividend; its MSBs shift into the partial remainder
    // while quotient bits shift in at the bottom.
    assign shifted   = {rem_q[W-2:0], quo_q[W-1]};
    assign fits      = {rem_q, quo_q[W-1]} >= {1'b0, dsr_q};
    assign remainder = fits ? shifted - dsr_q : shifted;
    assign quotient  = {quo_q[W-2:0], fits};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= remainder;
            quo_q <= quotient;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M EX-stage sequencer: registered multiply or iterative divide, stalling
// the pipeline while busy and returning the result with a one-cycle done pulse.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e          state;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic [CW-1:0]   counter;
    logic            neg_q, neg_r;

    logic            accept, sgn_in, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, quo_next, rem_next, div_res;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign busy     = (state == S_MUL) || (state == S_DIV) || accept;
    assign sgn_in   = is_signed_div(funct3);
    assign div_zero = (rs2 == '0);
    assign div_ovf  = sgn_in && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign mag_a    = (sgn_in && rs1[XLEN-1]) ? -rs1 : rs1;
    assign mag_b    = (sgn_in && rs2[XLEN-1]) ? -rs2 : rs2;

    // Sign-extending to 2*XLEN and keeping the low 2*XLEN bits of the
    // product gives the same bits as an (XLEN+1)-bit signed multiply.
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_x, b_x, prod;
    logic [XLEN-1:0] mul_res;

    assign a_sgn   = (op == F3_MULH) || (op == F3_MULHSU);
    assign b_sgn   = (op == F3_MULH);
    assign a_x     = {{XLEN{a_sgn & a[XLEN-1]}}, a};
    assign b_x     = {{XLEN{b_sgn & b[XLEN-1]}}, b};
    assign prod    = a_x * b_x;
    assign mul_res = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign div_res = op[1] ? (neg_r ? -rem_next : rem_next)
                           : (neg_q ? -quo_next : quo_next);

    restoring_divider #(.W(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && funct3[2]),
        .step      (state == S_DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo_next),
        .remainder (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            result  <= '0;
            counter <= '0;
            op      <= '0;
            a       <= '0;
            b       <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state   <= S_IDLE;
                counter <= '0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        op    <= funct3;
                        a     <= rs1;
                        b     <= rs2;
                        neg_q <= sgn_in && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        neg_r <= sgn_in && rs1[XLEN-1];
                        if (!funct3[2]) begin
                            state <= S_MUL;
                        end else if (div_zero) begin
                            result <= funct3[1] ? rs1 : '1;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (div_ovf) begin
                            result <= funct3[1] ? '0 : rs1;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            counter <= CW'(XLEN);
                            state   <= S_DIV;
                        end
                    end
                    S_MUL: begin
                        result <= mul_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DIV: begin
                        counter <= counter - CW'(1);
                        if (counter == CW'(1)) begin
                            result <= div_res;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                    // start here still belongs to the retiring instruction
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M extension in the EX stage. When the decoded instruction is OP_R3 with funct7 = 0000001, it captures the operands and runs either a registered multiply or an iterative restoring divide. While it works it asserts a stall to the pipeline, and it returns the result with a one-cycle done pulse. A branch/jump flush aborts it. It is the only owner of the multiply/divide hardware, so at most one M-op is in flight.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX-stage valid M-op (opcode OP_R3, funct7 = 0000001)
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A / dividend
- rs2  in  XLEN  operand B / divisor
- flush  in  1  kill in-flight op (taken branch/jump redirect)
- busy  out  1  stall request to IF/ID/EX pipeline registers
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  write-back value, held until next done

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset: state IDLE; busy 0, done 0, result 0, counter 0.
- IDLE
  - start && !flush: latch funct3, rs1, rs2.
  - funct3[2] = 0 → MUL.
  - funct3[2] = 1 and special case → DONE with the special result loaded.
  - Otherwise → DIV with counter = XLEN.
- MUL
  - Operands are extended to XLEN+1 bits: rs1 signed for MULH/MULHSU, rs2 signed for MULH only, zero-extended otherwise.
  - Signed product is registered.
  - MUL returns product[XLEN-1:0]; the other multiplies return product[2XLEN-1:XLEN].
  - → DONE.
- DIV
  - Restoring divide on magnitudes (signed ops use |rs1|, |rs2|), one quotient bit per cycle.
  - Counter decrements each cycle; when it reaches 0 → DONE.
  - Sign fix: quotient negated when signed and the operand signs differ; remainder takes the dividend's sign.
- Special cases (no iteration):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE: done = 1 and result is valid. Always → IDLE. start is ignored in DONE because it still belongs to the completing instruction.
- flush in any state → IDLE next cycle, no done pulse, result unchanged. Priority order: rst > flush > start.
- busy = (state ∈ {MUL, DIV}) || (state = IDLE && start && !flush). busy is combinational, so the stall takes effect in the same cycle as start. busy is 0 in DONE so the pipeline advances.

## Timing
- start sampled in cycle t.
- MUL: done at t+2.
- DIV/REM normal case: DIV states t+1 … t+XLEN, done at t+XLEN+1 (t+33 for XLEN=32).
- Special-case divide: done at t+1.
- Back-to-back M-ops: the second start arrives in IDLE at the earliest at done+1. No bubble is needed beyond that.
- rst or flush asserted mid-operation: busy drops the next cycle and counter/state are cleared.

## Structure
- Add the funct3 M-op encodings and FUNCT7_MULDIV (7'b0000001) to inst_defs.sv next to the existing OP_/FUNCT defines. The decoder shares them.
- The state enum stays local to the module.
- One sub-module, restoring_divider: unsigned shift-subtract datapath with load/step inputs and quotient/remainder outputs. The sequencer owns the sign handling and the counter.

## Test plan
- MULH, rs1 = 0xFFFFFFFE (−2), rs2 = 0x00000003 → done at t+2, result 0xFFFFFFFF; busy high at t and t+1, low at t+2.
- MULHU, rs1 = rs2 = 0xFFFFFFFF → result 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIV, rs1 = 0xFFFFFFF9 (−7), rs2 = 2 → done at t+33, result 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU by 0 → 0xFFFFFFFF at t+1. REM 0x80000000 / 0xFFFFFFFF → 0 at t+1. DIV with the same operands → 0x80000000.
- DIVU 100/7 with flush at t+10 → busy low at t+11, no done pulse. A new MUL 6×7 then gives 42 with correct timing.
- rst asserted at t+5 of a DIV → busy, done and result all 0 the next cycle. Two consecutive MUL ops complete without losing or duplicating a done pulse.
